// File: rtl/clock_divider.sv
// Programmable clock divider: registered divided clock, period-start tick and load acknowledge.
// Optional feature macro: CLOCK_DIVIDER_TICK_EN builds the tick register; otherwise tick is tied low.
module clock_divider #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] DIV_RESET = WIDTH'(10)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             ack
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             pf_q, pf_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] div_sat;
    logic             wrap;

    // Divisors below 2 cannot form a period with both phases, so clamp to 2.
    assign div_sat = (div < WIDTH'(2)) ? WIDTH'(2) : div;
    assign wrap    = (cnt_q == a_q - WIDTH'(1));

    always_comb begin
        a_d       = a_q;
        p_d       = p_q;
        pf_d      = pf_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        ack_d     = 1'b0;
        if (en) begin
            if (wrap) begin
                cnt_d = '0;
                if (load) begin
                    a_d   = div_sat;
                    ack_d = 1'b1;
                    pf_d  = 1'b0;
                end else if (pf_q) begin
                    a_d   = p_q;
                    ack_d = 1'b1;
                    pf_d  = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                if (load) begin
                    p_d  = div_sat;
                    pf_d = 1'b1;
                end
            end
            // High phase is the ceiling half so odd divisors stretch the high time.
            clk_out_d = (cnt_d < (a_d - (a_d >> 1)));
        end else if (load) begin
            p_d  = div_sat;
            pf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= DIV_RESET;
            p_q       <= '0;
            pf_q      <= 1'b0;
            cnt_q     <= DIV_RESET - WIDTH'(1);
            clk_out_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            a_q       <= a_d;
            p_q       <= p_d;
            pf_q      <= pf_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            ack_q     <= ack_d;
        end
    end

    assign clk_out = clk_out_q;
    assign ack     = ack_q;

`ifdef CLOCK_DIVIDER_TICK_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = en && wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter WIDTH, default 16: width of the divisor and of the internal counter.
REQ-002 Parameter DIV_RESET, default 10: divisor in effect after reset; legal range 2..2^WIDTH-1.
REQ-003 clk  input  1  system clock; the only clock of the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; when low, all state holds.
REQ-006 div  input  WIDTH  requested divisor N; sampled only when load=1.
REQ-007 load  input  1  single-cycle request to adopt div.
REQ-008 clk_out  output  1  registered divided clock with period N clk cycles.
REQ-009 tick  output  1  registered one-cycle pulse marking the start of each clk_out period.
REQ-010 ack  output  1  registered one-cycle pulse when a loaded divisor takes effect.

Function
REQ-011 The block SHALL hold an active divisor A, a pending divisor P, a pending flag pf, and a counter cnt in the range 0..A-1.
REQ-012 On an edge with en=1 and cnt≠A-1, the block SHALL set cnt to cnt+1.
REQ-013 On an edge with en=1 and cnt=A-1 (wrap), the block SHALL set cnt to 0, and if pf=1 or load=1 it SHALL set A to the divisor in effect (REQ-017), set ack=1 for that cycle, and clear pf.
REQ-014 clk_out SHALL be registered as (new cnt < H), where H = A_new - floor(A_new/2): high H cycles, low floor(A_new/2) cycles; odd N gives a longer high phase.
REQ-015 tick SHALL be 1 exactly in the cycle after an edge on which cnt became 0 with en=1, and 0 otherwise.
REQ-016 A load=1 edge without a wrap SHALL capture div into P and set pf; a later load before the wrap overwrites P, so only the last value applies and a single ack is produced.
REQ-017 When load=1 coincides with a wrap, div SHALL apply at that wrap, taking priority over any older P.
REQ-018 A div value of 0 or 1 SHALL be treated as 2, with no other error reporting.
REQ-019 With en=0, cnt, A, clk_out and P SHALL hold, tick and ack SHALL be 0, and load SHALL still capture into P.
REQ-020 A divisor change SHALL never truncate or extend the current period: no runt pulses on clk_out.
REQ-021 Latency: the first clk_out high and tick SHALL appear in the cycle after the first enabled edge following reset.

Reset
REQ-022 While rst_n=0, the block SHALL force cnt=A-1, A=DIV_RESET, P=0, pf=0, clk_out=0, tick=0 and ack=0, asynchronously.
REQ-023 Because reset sets cnt=A-1, the first enabled edge SHALL wrap to 0 and start a clean period.
REQ-024 A reset mid-period or with a pending load SHALL discard the partial period and the pending divisor.
REQ-025 Release of reset SHALL be assumed synchronous to clk by the integrating level.

Configuration
REQ-026 Macro CLOCK_DIVIDER_TICK_EN SHALL select the tick feature.
REQ-027 With CLOCK_DIVIDER_TICK_EN defined, tick SHALL behave per REQ-015.
REQ-028 Without CLOCK_DIVIDER_TICK_EN, tick SHALL be tied to 0, its register SHALL not be built, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, en=1, DIV_RESET=10 -> clk_out 5 cycles high / 5 low repeating; tick every 10 cycles, first tick 1 cycle after the first enabled edge.
REQ-030 load with div=7 mid-period -> current 10-cycle period completes intact; ack at the wrap; then clk_out 4 high / 3 low.
REQ-031 load div=4 then load div=6 before the wrap; separately, load div=3 exactly on the wrap edge -> only 6 applied with one ack; 3 applied at that same wrap.
REQ-032 load div=0 and div=1 -> each behaves as N=2 (1 high / 1 low, tick every 2 cycles).
REQ-033 en dropped for 8 cycles at cnt=3 -> outputs frozen, tick/ack 0; on resume, period continues from cnt=4 with no glitch.
REQ-034 rst_n asserted asynchronously mid-period with a pending load -> outputs 0 immediately; after release, N=10 restored and the pending divisor is lost; repeat the build without CLOCK_DIVIDER_TICK_EN -> tick constantly 0.
